// File: rtl/argmax_pkg.sv
// Shared types and defaults for the sequential argmax front-end.
package argmax_pkg;

    localparam int DATA_W      = 4;
    localparam int DEF_MAX_LEN = 16;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic {
        COLLECT = 1'b0,
        REPORT  = 1'b1
    } state_t;

endpackage : argmax_pkg

// File: rtl/argmax_seq_gt_cmp.sv
// Unsigned strict greater-than between two samples.
module gt_cmp
    import argmax_pkg::*;
(
    input  data_t a,
    input  data_t b,
    output logic  gt
);

    // Strictly greater, so equal values never displace the earlier winner.
    always_comb begin
        gt = (a > b);
    end

endmodule : gt_cmp

// File: rtl/argmax_seq.sv
// Sequential argmax: tracks the running maximum and its first index over a
// frame of samples, then holds the result until downstream consumes it.
module argmax_seq
    import argmax_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W:0]    out_len,
    output logic              out_trunc
);

    localparam int                CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_LEN - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    data_t             max_r;
    logic [IDX_W-1:0]  idx_r;

    logic              gt;
    logic              accept;
    logic              take_new;
    logic              at_limit;
    logic              close;
    data_t             next_max;
    logic [IDX_W-1:0]  next_idx;
    logic [CNT_W-1:0]  next_cnt;

    gt_cmp u_gt_cmp (
        .a  (in_data),
        .b  (max_r),
        .gt (gt)
    );

    // Handshake flags decode from state alone, so nothing on in_* reaches them.
    always_comb begin
        in_ready  = (state == COLLECT);
        out_valid = (state == REPORT);
    end

    // Per-sample update, including the sample that closes the frame.
    always_comb begin
        accept   = in_valid && in_ready;
        take_new = (cnt == '0) || gt;
        next_max = take_new ? in_data : max_r;
        next_idx = take_new ? cnt[IDX_W-1:0] : idx_r;
        next_cnt = cnt + 1'b1;
        at_limit = (cnt == LAST_CNT);
        close    = accept && (in_last || at_limit);
    end

    // FSM, running max/index/count, and held result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            cnt       <= '0;
            max_r     <= '0;
            idx_r     <= '0;
            out_max   <= '0;
            out_idx   <= '0;
            out_len   <= '0;
            out_trunc <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        max_r <= next_max;
                        idx_r <= next_idx;
                        cnt   <= next_cnt;
                    end
                    if (close) begin
                        state     <= REPORT;
                        out_max   <= next_max;
                        out_idx   <= next_idx;
                        out_len   <= next_cnt;
                        out_trunc <= !in_last;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state <= COLLECT;
                        cnt   <= '0;
                        max_r <= '0;
                        idx_r <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule : argmax_seq
